// File: rtl/kb_instruction_ctrl.sv
// -----------------------------------------------------------------------------
// kb_instruction_ctrl
//
// Purpose:
//   Turns raw PS/2 scan codes into the two-player 8-bit instruction word that
//   the game logic samples once per game tick. The block:
//     - parses make, break (F0) and extended (E0) prefixes;
//     - tracks which keys each player is holding;
//     - picks one direction per player when several are held;
//     - emits one instruction per tick, handling pause and reset requests.
//
// Configuration macro:
//   KB_FIRE_LATCH_EN
//     Defined: a fire make is latched until the next normal word is emitted,
//              so a tap shorter than a tick period still fires once.
//     Undefined (default): the fire bit is the live held flag only.
//
// Parameters:
//   PREFIX_TIMEOUT  idle cycles allowed after a prefix before the parser gives up
//   TIMEOUT_W       width of the prefix timeout counter
//
// Ports:
//   i_clk                rising-edge system clock
//   i_reset              synchronous active-high reset; clears all state
//   i_scan_code[7:0]     scan code byte from the keyboard interface
//   i_scan_code_ready    1-cycle strobe, i_scan_code valid this cycle
//   i_game_tick          1-cycle strobe, game samples an instruction
//   o_instruction[7:0]   [7:4] P1, [3:0] P2; each nibble is {fire, move[2:0]}
//   o_instruction_valid  1-cycle pulse, the cycle after i_game_tick
//   o_paused             level, game paused
// -----------------------------------------------------------------------------
module kb_instruction_ctrl #(
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_scan_code,
  input  logic       i_scan_code_ready,
  input  logic       i_game_tick,
  output logic [7:0] o_instruction,
  output logic       o_instruction_valid,
  output logic       o_paused
);

  // Key indices into the held-flag vector.
  localparam int K_P1_UP = 0, K_P1_DN = 1, K_P1_LF = 2, K_P1_RT = 3, K_P1_FIRE = 4;
  localparam int K_P2_UP = 5, K_P2_DN = 6, K_P2_LF = 7, K_P2_RT = 8, K_P2_FIRE = 9;
  localparam int K_RESET = 10, K_PAUSE = 11;
  localparam int NKEYS   = 12;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NKEYS-1:0]     w_make_oh, w_brk_oh;

  logic [NKEYS-1:0]     r_held;
  logic [1:0]           r_last1, r_last2;
  logic                 r_reset_pending;
  logic                 r_paused;
  logic [7:0]           r_instr;
  logic                 r_valid;

  // One-hot key for a scan code; zero when the code is not mapped.
  function automatic logic [NKEYS-1:0] key_oh(input logic [7:0] code, input logic ext);
    logic [NKEYS-1:0] oh;
    oh = '0;
    if (ext) begin
      case (code)
        8'h75:   oh[K_P2_UP] = 1'b1;
        8'h72:   oh[K_P2_DN] = 1'b1;
        8'h6B:   oh[K_P2_LF] = 1'b1;
        8'h74:   oh[K_P2_RT] = 1'b1;
        default: oh = '0;
      endcase
    end else begin
      case (code)
        8'h1D:   oh[K_P1_UP]   = 1'b1;
        8'h1B:   oh[K_P1_DN]   = 1'b1;
        8'h1C:   oh[K_P1_LF]   = 1'b1;
        8'h23:   oh[K_P1_RT]   = 1'b1;
        8'h29:   oh[K_P1_FIRE] = 1'b1;
        8'h70:   oh[K_P2_FIRE] = 1'b1;
        8'h2D:   oh[K_RESET]   = 1'b1;
        8'h4D:   oh[K_PAUSE]   = 1'b1;
        default: oh = '0;
      endcase
    end
    return oh;
  endfunction

  // Direction index (0 up, 1 down, 2 left, 3 right) to move code.
  function automatic logic [2:0] dir_code(input logic [1:0] idx);
    logic [2:0] m;
    case (idx)
      2'd0:    m = 3'b010;
      2'd1:    m = 3'b111;
      2'd2:    m = 3'b100;
      default: m = 3'b001;
    endcase
    return m;
  endfunction

  // Lowest set bit of a 4-bit direction group; a make event sets only one bit.
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    if (oh[0])      idx = 2'd0;
    else if (oh[1]) idx = 2'd1;
    else if (oh[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // Last-pressed direction wins while still held; otherwise fixed-order fallback.
  function automatic logic [2:0] arbitrate(input logic [3:0] held, input logic [1:0] last);
    logic [2:0] m;
    if (held[last])   m = dir_code(last);
    else if (held[0]) m = dir_code(2'd0);
    else if (held[1]) m = dir_code(2'd1);
    else if (held[2]) m = dir_code(2'd2);
    else if (held[3]) m = dir_code(2'd3);
    else              m = 3'b000;
    return m;
  endfunction

  // Parser: next state, timeout counter and make/break events.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_make_oh   = '0;
    w_brk_oh    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_scan_code_ready) begin
          if (i_scan_code == 8'hE0)      w_state_nxt = S_EXT;
          else if (i_scan_code == 8'hF0) w_state_nxt = S_BRK;
          else                           w_make_oh   = key_oh(i_scan_code, 1'b0);
        end
      end
      S_EXT: begin
        if (i_scan_code_ready) begin
          if (i_scan_code == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_make_oh   = key_oh(i_scan_code, 1'b1);
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_BRK: begin
        if (i_scan_code_ready) begin
          w_brk_oh    = key_oh(i_scan_code, 1'b0);
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (i_scan_code_ready) begin
          w_brk_oh    = key_oh(i_scan_code, 1'b1);
          w_state_nxt = S_IDLE;
        end
      end
    endcase
    // A prefix with no following byte for too long is abandoned silently.
    if (r_state != S_IDLE && !i_scan_code_ready) begin
      if (r_cnt == TIMEOUT_LAST) w_state_nxt = S_IDLE;
      else                       w_cnt_nxt   = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Key tracking and instruction assembly.
  logic             w_tick_rst, w_tick_norm;
  logic [NKEYS-1:0] w_new_make, w_held_nxt;
  logic             w_fire1, w_fire2;
  logic [7:0]       w_word;

  assign w_tick_rst  = i_game_tick && r_reset_pending;
  assign w_tick_norm = i_game_tick && !r_reset_pending && !r_paused;
  // Typematic repeats of a held key are not new presses.
  assign w_new_make  = w_make_oh & ~r_held;
  // The reset word wipes held flags, then this cycle's key event still lands.
  assign w_held_nxt  = ((w_tick_rst ? '0 : r_held) | w_make_oh) & ~w_brk_oh;

`ifdef KB_FIRE_LATCH_EN
  logic r_fire_pend1, r_fire_pend2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fire_pend1 <= 1'b0;
      r_fire_pend2 <= 1'b0;
    end else begin
      // A fire make in the same cycle as the clearing tick wins, so it
      // survives to the following tick.
      r_fire_pend1 <= (r_fire_pend1 && !(w_tick_norm || w_tick_rst)) || w_new_make[K_P1_FIRE];
      r_fire_pend2 <= (r_fire_pend2 && !(w_tick_norm || w_tick_rst)) || w_new_make[K_P2_FIRE];
    end
  end

  assign w_fire1 = r_held[K_P1_FIRE] | r_fire_pend1;
  assign w_fire2 = r_held[K_P2_FIRE] | r_fire_pend2;
`else
  assign w_fire1 = r_held[K_P1_FIRE];
  assign w_fire2 = r_held[K_P2_FIRE];
`endif

  assign w_word = {w_fire1, arbitrate(r_held[K_P1_RT:K_P1_UP], r_last1),
                   w_fire2, arbitrate(r_held[K_P2_RT:K_P2_UP], r_last2)};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_held          <= '0;
      r_last1         <= 2'd0;
      r_last2         <= 2'd0;
      r_reset_pending <= 1'b0;
      r_paused        <= 1'b0;
      r_instr         <= 8'h00;
      r_valid         <= 1'b0;
    end else begin
      r_held          <= w_held_nxt;
      if (|w_new_make[K_P1_RT:K_P1_UP]) r_last1 <= oh2idx(w_new_make[K_P1_RT:K_P1_UP]);
      if (|w_new_make[K_P2_RT:K_P2_UP]) r_last2 <= oh2idx(w_new_make[K_P2_RT:K_P2_UP]);
      r_reset_pending <= (r_reset_pending && !i_game_tick) || w_new_make[K_RESET];
      r_paused        <= (w_tick_rst ? 1'b0 : r_paused) ^ w_new_make[K_PAUSE];
      // Output stage: the tick samples state from before this cycle's update.
      r_valid         <= i_game_tick;
      if (i_game_tick) begin
        if (r_reset_pending) r_instr <= 8'hFF;
        else if (r_paused)   r_instr <= 8'hFE;
        else                 r_instr <= w_word;
      end
    end
  end

  assign o_instruction       = r_instr;
  assign o_instruction_valid = r_valid;
  assign o_paused            = r_paused;

endmodule

// File: tb/tb_kb_instruction_ctrl.sv
module tb_kb_instruction_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       game_tick;
  logic [7:0] instruction;
  logic       instruction_valid;
  logic       paused;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  kb_instruction_ctrl #(.PREFIX_TIMEOUT(50000), .TIMEOUT_W(16)) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_scan_code         (scan_code),
    .i_scan_code_ready   (scan_code_ready),
    .i_game_tick         (game_tick),
    .o_instruction       (instruction),
    .o_instruction_valid (instruction_valid),
    .o_paused            (paused)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every valid pulse pops one expected word.
  always @(negedge clk) begin
    if (instruction_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid got=%h required=none", instruction);
      end
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (instruction === e) else begin
          errors++;
          $error("FAIL instruction got=%h required=%h", instruction, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] req);
    checks++;
    assert (got === req) else begin
      errors++;
      $error("FAIL %s got=%h required=%h", tag, got, req);
    end
  endtask

  task automatic send(input logic [7:0] code);
    @(negedge clk);
    scan_code = code;
    scan_code_ready = 1'b1;
    @(negedge clk);
    scan_code_ready = 1'b0;
  endtask

  // Tick and check the single-cycle pulse; the word itself is checked by the scoreboard.
  task automatic tick(input logic [7:0] e);
    @(negedge clk);
    game_tick = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    game_tick = 1'b0;
    @(negedge clk);
    chk("valid_pulse_end", {7'd0, instruction_valid}, 8'h00);
    chk("instr_hold", instruction, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    scan_code = 8'h00;
    scan_code_ready = 1'b0;
    game_tick = 1'b0;
    idle(3);
    chk("rst_instr", instruction, 8'h00);
    chk("rst_valid", {7'd0, instruction_valid}, 8'h00);
    chk("rst_paused", {7'd0, paused}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // P1 up press and release.
    send(8'h1D); tick(8'h20);
    send(8'hF0); send(8'h1D); tick(8'h00);

    // P2 extended up plus P1 left.
    send(8'hE0); send(8'h75); send(8'h1C); tick(8'h42);
    send(8'hF0); send(8'h1C); tick(8'h02);
    send(8'hE0); send(8'hF0); send(8'h75); tick(8'h00);

    // Last pressed wins, fallback to up when down released.
    send(8'h1D); send(8'h1B); tick(8'h70);
    send(8'hF0); send(8'h1B); tick(8'h20);
    send(8'hF0); send(8'h1D); tick(8'h00);

    // Last pressed (right) beats fixed order; repeat of left changes nothing.
    send(8'h1C); send(8'h23); send(8'h1C); tick(8'h10);
    send(8'hF0); send(8'h23); tick(8'h40);
    send(8'hF0); send(8'h1C); tick(8'h00);

    // Pause toggle; key tracking continues while paused.
    send(8'h4D); send(8'hF0); send(8'h4D);
    chk("paused_on", {7'd0, paused}, 8'h01);
    tick(8'hFE);
    send(8'h23);
    send(8'h4D); send(8'hF0); send(8'h4D);
    chk("paused_off", {7'd0, paused}, 8'h00);
    tick(8'h10);
    send(8'hF0); send(8'h23); tick(8'h00);

    // Reset request with fire held; paused also cleared by the reset word.
    send(8'h4D); send(8'hF0); send(8'h4D);
    send(8'h29); send(8'h2D); send(8'hF0); send(8'h2D);
    tick(8'hFF);
    chk("paused_after_ff", {7'd0, paused}, 8'h00);
    tick(8'h00);
    send(8'hF0); send(8'h29); tick(8'h00);

    // Tick and make in the same cycle: tick sees the old state.
    @(negedge clk);
    scan_code = 8'h1D; scan_code_ready = 1'b1; game_tick = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    scan_code_ready = 1'b0; game_tick = 1'b0;
    tick(8'h20);
    send(8'hF0); send(8'h1D); tick(8'h00);

    // Fire tap between ticks.
    send(8'h29); send(8'hF0); send(8'h29);
`ifdef KB_FIRE_LATCH_EN
    tick(8'h80);
`else
    tick(8'h00);
`endif
    tick(8'h00);

    // A short gap after E0 is still within the prefix window.
    send(8'hE0); idle(100); send(8'h75); tick(8'h02);
    send(8'hE0); send(8'hF0); send(8'h75); tick(8'h00);

    // Prefix timeout: 75 afterwards is a plain, unmapped code.
    send(8'hE0); idle(60000); send(8'h75); tick(8'h00);

    // Reset mid-prefix returns the parser to IDLE.
    send(8'hE0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send(8'h75); tick(8'h00);

    // Reset coinciding with a tick: no pulse, held keys cleared.
    send(8'h1D);
    @(negedge clk); reset = 1'b1; game_tick = 1'b1;
    @(negedge clk); reset = 1'b0; game_tick = 1'b0;
    chk("rst_tick_valid", {7'd0, instruction_valid}, 8'h00);
    chk("rst_tick_instr", instruction, 8'h00);
    tick(8'h00);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
